aes_uart_ctrl: RTL and testbench

- Command sequencer between the UART byte-level receiver/transmitter pair and the AES core.
- Parses single-byte commands arriving on the RX byte stream and assembles 16-byte key and plaintext blocks.
- Launches an encryption, emits the trace trigger for side-channel capture, then serializes the 16-byte ciphertext back through the UART transmitter.
- Replaces the RX→TX loopback wiring at the top level.

---
 rtl/aes_uart_ctrl_if.sv | 28 ++
 rtl/aes_uart_ctrl.sv | 135 +++++++++++++
 tb/tb_aes_uart_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_uart_ctrl_if.sv
// Handshake bundle between the AES/UART command sequencer and its UART and AES neighbours.
// The master modport is the sequencer's view; slave is the environment's view.
interface aes_uart_ctrl_if;
    logic         i_Rx_DV;
    logic [7:0]   i_Rx_Byte;
    logic         o_Tx_DV;
    logic [7:0]   o_Tx_Byte;
    logic         i_Tx_Active;
    logic         i_Tx_Done;
    logic [127:0] o_Key;
    logic [127:0] o_Plaintext;
    logic         o_Aes_Start;
    logic         i_Aes_Done;
    logic [127:0] i_Ciphertext;
    logic         o_Trigger;
    logic         o_Busy;
    logic         o_Timeout;

    modport master (
        input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done, i_Aes_Done, i_Ciphertext,
        output o_Tx_DV, o_Tx_Byte, o_Key, o_Plaintext, o_Aes_Start, o_Trigger, o_Busy, o_Timeout
    );

    modport slave (
        output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done, i_Aes_Done, i_Ciphertext,
        input  o_Tx_DV, o_Tx_Byte, o_Key, o_Plaintext, o_Aes_Start, o_Trigger, o_Busy, o_Timeout
    );
endinterface

// File: rtl/aes_uart_ctrl.sv
// Command sequencer: assembles key/plaintext blocks from UART bytes, runs one AES
// encryption with a scope trigger around it, and streams the ciphertext back out.
module aes_uart_ctrl #(
    parameter int         TIMEOUT_CLKS = 1000000,
    parameter logic [7:0] CMD_KEY      = 8'h4B,
    parameter logic [7:0] CMD_PT       = 8'h50
) (
    input logic            i_Clk,
    input logic            i_Rst,
    aes_uart_ctrl_if.master bus
);
    localparam int           TW       = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 2);

    typedef enum logic [2:0] {IDLE, RX_KEY, RX_PT, AES_RUN, TX_SEND, TX_WAIT} state_t;

    state_t        state, state_next;
    logic [3:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [119:0]  rx_buf;
    logic [127:0]  rx_word;
    logic [127:0]  tx_shift;
    logic          rx_take, cnt_clear, key_load, pt_load, tmo_fire;
    logic          ct_capture, tx_fire, tx_advance;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state <= IDLE;
        else       state <= state_next;
    end

    // The timeout fires on the edge where the idle counter would reach TIMEOUT_CLKS-1.
    always_comb begin
        state_next = state;
        rx_take    = 1'b0;
        cnt_clear  = 1'b0;
        key_load   = 1'b0;
        pt_load    = 1'b0;
        tmo_fire   = 1'b0;
        ct_capture = 1'b0;
        tx_fire    = 1'b0;
        tx_advance = 1'b0;
        rx_word    = {rx_buf, bus.i_Rx_Byte};
        case (state)
            IDLE: begin
                if (bus.i_Rx_DV) begin
                    if (bus.i_Rx_Byte == CMD_KEY) begin
                        state_next = RX_KEY;
                        cnt_clear  = 1'b1;
                    end else if (bus.i_Rx_Byte == CMD_PT) begin
                        state_next = RX_PT;
                        cnt_clear  = 1'b1;
                    end
                end
            end
            RX_KEY, RX_PT: begin
                if (bus.i_Rx_DV) begin
                    rx_take = 1'b1;
                    if (byte_cnt == 4'd15) begin
                        if (state == RX_KEY) begin
                            key_load   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            pt_load    = 1'b1;
                            state_next = AES_RUN;
                        end
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            AES_RUN: begin
                // A done strobe coinciding with our own start pulse cannot be a real result.
                if (bus.i_Aes_Done && !bus.o_Aes_Start) begin
                    ct_capture = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!bus.i_Tx_Active) begin
                    tx_fire    = 1'b1;
                    state_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (bus.i_Tx_Done) begin
                    tx_advance = 1'b1;
                    state_next = (byte_cnt == 4'd15) ? IDLE : TX_SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            byte_cnt        <= 4'd0;
            tmo_cnt         <= '0;
            rx_buf          <= '0;
            tx_shift        <= '0;
            bus.o_Tx_DV     <= 1'b0;
            bus.o_Tx_Byte   <= 8'h00;
            bus.o_Key       <= '0;
            bus.o_Plaintext <= '0;
            bus.o_Aes_Start <= 1'b0;
            bus.o_Trigger   <= 1'b0;
            bus.o_Busy      <= 1'b0;
            bus.o_Timeout   <= 1'b0;
        end else begin
            bus.o_Aes_Start <= pt_load;
            bus.o_Timeout   <= tmo_fire;
            bus.o_Tx_DV     <= tx_fire;
            bus.o_Busy      <= (state_next != IDLE);

            if (cnt_clear)                 byte_cnt <= 4'd0;
            else if (rx_take || tx_advance) byte_cnt <= byte_cnt + 4'd1;

            if ((state == RX_KEY || state == RX_PT) && !bus.i_Rx_DV) tmo_cnt <= tmo_cnt + TW'(1);
            else                                                     tmo_cnt <= '0;

            if (rx_take)  rx_buf          <= rx_word[119:0];
            if (key_load) bus.o_Key       <= rx_word;
            if (pt_load)  bus.o_Plaintext <= rx_word;

            if (pt_load)         bus.o_Trigger <= 1'b1;
            else if (ct_capture) bus.o_Trigger <= 1'b0;

            if (ct_capture)      tx_shift <= bus.i_Ciphertext;
            else if (tx_advance) tx_shift <= {tx_shift[119:0], 8'h00};

            if (tx_fire) bus.o_Tx_Byte <= tx_shift[127:120];
        end
    end
endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Bench for aes_uart_ctrl: behavioural UART transmitter and AES core responders, a
// block-level reference model of key/plaintext/ciphertext flow, and directed corner cases.
module tb_aes_uart_ctrl;
    localparam int           TMO      = 50;
    localparam logic [7:0]   CMD_KEY  = 8'h4B;
    localparam logic [7:0]   CMD_PT   = 8'h50;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] FIPS_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    typedef struct {
        logic [7:0] b;
        logic       exp_busy;
    } idle_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_uart_ctrl_if bus();

    aes_uart_ctrl #(.TIMEOUT_CLKS(TMO), .CMD_KEY(CMD_KEY), .CMD_PT(CMD_PT)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int           checks     = 0;
    int           failures   = 0;
    logic [7:0]   tx_q[$];
    int           start_cnt  = 0;
    int           tmo_pulses = 0;
    logic [127:0] key_model  = '0;

    int           aes_timer  = 0;
    int           tx_timer   = 0;
    int           tx_hold    = 0;
    logic         tx_busy    = 1'b0;
    logic         prev_busy  = 1'b0;
    logic         prev_active = 1'b0;
    logic [7:0]   tx_cur     = 8'h00;
    logic         trig_model = 1'b0;
    logic [127:0] aes_result = '0;

    // Stand-in for the AES core: the real FIPS-197 vector, otherwise an arbitrary mixing function.
    function automatic logic [127:0] aes_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return {p[63:0], p[127:64]} ^ k ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        @(negedge clk);
        bus.i_Rx_DV   = 1'b0;
        bus.i_Rx_Byte = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic load_block(input logic [7:0] cmd, input logic [127:0] data, input int max_gap);
        apply_stimulus(cmd, $urandom_range(0, max_gap));
        for (int i = 0; i < 16; i++)
            apply_stimulus(data[127-8*i -: 8], (i == 15) ? 0 : $urandom_range(0, max_gap));
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 4000 && tx_q.size() < n; i++) @(negedge clk);
        check_output("tx_count", 128'(tx_q.size()), 128'(n));
    endtask

    task automatic run_pt(input logic [127:0] pt, input bit inject);
        int           base;
        int           starts;
        logic [127:0] exp_ct;
        logic [127:0] key_before;
        base       = tx_q.size();
        starts     = start_cnt;
        key_before = key_model;
        exp_ct     = aes_fn(key_model, pt);
        load_block(CMD_PT, pt, 2);
        check_output("pt_loaded", bus.o_Plaintext, pt);
        check_output("trigger_at_start", 128'(bus.o_Trigger), 128'(1'b1));
        if (inject) begin
            repeat (2) @(negedge clk);
            apply_stimulus(($urandom_range(0, 1) == 0) ? CMD_KEY : CMD_PT, 0);
            wait_tx(base + 4);
            apply_stimulus(CMD_PT, 0);
            apply_stimulus(CMD_KEY, 0);
        end
        wait_tx(base + 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < tx_q.size())
                check_output($sformatf("ct_byte%0d", i), 128'(tx_q[base+i]), 128'(exp_ct[127-8*i -: 8]));
            else
                check_output($sformatf("ct_byte%0d_missing", i), 128'(1'b0), 128'(1'b1));
        end
        repeat (6) @(negedge clk);
        check_output("busy_after_pt", 128'(bus.o_Busy), 128'(1'b0));
        check_output("one_start_pulse", 128'(start_cnt), 128'(starts + 1));
        check_output("tx_no_extra", 128'(tx_q.size()), 128'(base + 16));
        check_output("key_kept_after_pt", bus.o_Key, key_before);
    endtask

    // Environment: UART transmitter and AES core responders plus output monitors.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.i_Aes_Done  = 1'b0;
                bus.i_Tx_Done   = 1'b0;
                bus.i_Tx_Active = 1'b0;
                aes_timer       = 0;
                tx_busy         = 1'b0;
                tx_timer        = 0;
                tx_hold         = 0;
                trig_model      = 1'b0;
            end else begin
                prev_busy   = tx_busy;
                prev_active = bus.i_Tx_Active;

                if (bus.i_Aes_Done) trig_model = 1'b0;
                bus.i_Aes_Done   = 1'b0;
                bus.i_Ciphertext = {$urandom, $urandom, $urandom, $urandom};
                if (aes_timer > 0) begin
                    aes_timer--;
                    if (aes_timer == 0) begin
                        bus.i_Aes_Done   = 1'b1;
                        bus.i_Ciphertext = aes_result;
                    end
                end
                if (bus.o_Aes_Start) begin
                    start_cnt++;
                    trig_model = 1'b1;
                    aes_timer  = 10;
                    aes_result = aes_fn(bus.o_Key, bus.o_Plaintext);
                end
                check_output("trigger", 128'(bus.o_Trigger), 128'(trig_model));

                if (bus.o_Timeout) tmo_pulses++;

                if (bus.i_Tx_Done) begin
                    bus.i_Tx_Done = 1'b0;
                    tx_busy       = 1'b0;
                end else if (tx_busy) begin
                    if (tx_timer == 0) begin
                        bus.i_Tx_Done = 1'b1;
                        tx_hold       = $urandom_range(0, 2);
                        check_output("tx_byte_held", 128'(bus.o_Tx_Byte), 128'(tx_cur));
                    end else begin
                        tx_timer--;
                    end
                end else if (tx_hold > 0) begin
                    tx_hold--;
                end

                if (bus.o_Tx_DV) begin
                    check_output("tx_dv_while_busy", 128'({prev_busy, prev_active}), 128'(2'b00));
                    tx_q.push_back(bus.o_Tx_Byte);
                    tx_cur   = bus.o_Tx_Byte;
                    tx_busy  = 1'b1;
                    tx_timer = $urandom_range(0, 4);
                end
                bus.i_Tx_Active = tx_busy || (tx_hold > 0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle_vec_t    vecs[6];
        logic [127:0] data;
        logic [127:0] old_key;
        int           base;
        int           starts;
        int           waited;
        int           pulses;

        vecs[0] = '{8'h00, 1'b0};
        vecs[1] = '{8'h41, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h4C, 1'b0};
        vecs[4] = '{8'h70, 1'b0};
        vecs[5] = '{8'h6B, 1'b0};

        bus.i_Rx_DV      = 1'b0;
        bus.i_Rx_Byte    = 8'h00;
        bus.i_Tx_Active  = 1'b0;
        bus.i_Tx_Done    = 1'b0;
        bus.i_Aes_Done   = 1'b0;
        bus.i_Ciphertext = '0;
        rst              = 1'b1;

        repeat (3) @(negedge clk);
        check_output("rst_key",     bus.o_Key, '0);
        check_output("rst_pt",      bus.o_Plaintext, '0);
        check_output("rst_tx_dv",   128'(bus.o_Tx_DV), '0);
        check_output("rst_tx_byte", 128'(bus.o_Tx_Byte), '0);
        check_output("rst_start",   128'(bus.o_Aes_Start), '0);
        check_output("rst_trigger", 128'(bus.o_Trigger), '0);
        check_output("rst_busy",    128'(bus.o_Busy), '0);
        check_output("rst_timeout", 128'(bus.o_Timeout), '0);
        rst = 1'b0;

        $display("[TB] non-command bytes in IDLE");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].b, 0);
            check_output($sformatf("idle_busy_%h", vecs[i].b), 128'(bus.o_Busy), 128'(vecs[i].exp_busy));
            check_output($sformatf("idle_key_%h", vecs[i].b), bus.o_Key, key_model);
        end

        $display("[TB] key load 00..0F");
        apply_stimulus(CMD_KEY, 1);
        for (int i = 0; i < 15; i++) apply_stimulus(FIPS_KEY[127-8*i -: 8], $urandom_range(0, 2));
        check_output("key_no_partial", bus.o_Key, '0);
        check_output("busy_in_rx", 128'(bus.o_Busy), 128'(1'b1));
        apply_stimulus(FIPS_KEY[7:0], 0);
        check_output("key_loaded", bus.o_Key, FIPS_KEY);
        check_output("busy_after_key", 128'(bus.o_Busy), 128'(1'b0));
        check_output("no_tx_on_key", 128'(tx_q.size()), '0);
        key_model = FIPS_KEY;

        $display("[TB] FIPS-197 plaintext");
        base = tx_q.size();
        run_pt(FIPS_PT, 1'b0);
        data = '0;
        for (int i = 0; i < 16; i++) data[127-8*i -: 8] = tx_q[base+i];
        check_output("fips_ct", data, FIPS_CT);

        $display("[TB] partial key block timeout");
        old_key = bus.o_Key;
        pulses  = tmo_pulses;
        apply_stimulus(CMD_KEY, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(8'($urandom), 0);
        waited = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.o_Timeout) begin
                waited = i;
                break;
            end
        end
        check_output("timeout_delay", 128'(waited), 128'(TMO - 1));
        repeat (5) @(negedge clk);
        check_output("timeout_single", 128'(tmo_pulses), 128'(pulses + 1));
        check_output("timeout_key_kept", bus.o_Key, old_key);
        check_output("timeout_idle", 128'(bus.o_Busy), 128'(1'b0));
        data = {$urandom, $urandom, $urandom, $urandom};
        load_block(CMD_KEY, data, 3);
        check_output("key_after_timeout", bus.o_Key, data);
        key_model = data;

        $display("[TB] randomized commands with dropped bytes");
        for (int n = 0; n < 6; n++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                load_block(CMD_KEY, data, 3);
                key_model = data;
                check_output("rand_key", bus.o_Key, key_model);
            end else begin
                run_pt(data, 1'b1);
            end
        end

        $display("[TB] reset during ciphertext");
        data   = {$urandom, $urandom, $urandom, $urandom};
        base   = tx_q.size();
        load_block(CMD_PT, data, 1);
        for (int i = 0; i < 4000 && tx_q.size() < base + 8; i++) @(negedge clk);
        check_output("tx_reached_8", 128'(tx_q.size()), 128'(base + 8));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("arst_key",     bus.o_Key, '0);
        check_output("arst_pt",      bus.o_Plaintext, '0);
        check_output("arst_tx_dv",   128'(bus.o_Tx_DV), '0);
        check_output("arst_tx_byte", 128'(bus.o_Tx_Byte), '0);
        check_output("arst_start",   128'(bus.o_Aes_Start), '0);
        check_output("arst_trigger", 128'(bus.o_Trigger), '0);
        check_output("arst_busy",    128'(bus.o_Busy), '0);
        check_output("arst_timeout", 128'(bus.o_Timeout), '0);
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        key_model = '0;
        base      = tx_q.size();
        starts    = start_cnt;
        repeat (60) @(negedge clk);
        check_output("post_rst_no_tx", 128'(tx_q.size()), 128'(base));
        check_output("post_rst_no_start", 128'(start_cnt), 128'(starts));
        check_output("post_rst_idle", 128'(bus.o_Busy), '0);

        $display("[TB] plaintext after reset");
        run_pt({$urandom, $urandom, $urandom, $urandom}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
